// File: rtl/day6_rr_arbiter_4req.sv
// Four-requester round-robin arbiter with bounded hold time.
// Registered grant index drives a decoded one-hot grant bus.
module day6_rr_arbiter_4req #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    localparam int CW = $clog2(MAX_HOLD);
    localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t        state, state_nxt;
    logic [1:0]    ptr, ptr_nxt;
    logic [1:0]    idx_nxt;
    logic [CW-1:0] hold_cnt, hold_nxt;
    logic          valid_nxt, timeout_nxt;
    logic [3:0]    gnt_nxt;

    logic [1:0]    sel_idx;
    logic          sel_hit;
    logic          at_limit, owner_drop, release_now;

    assign at_limit    = (hold_cnt == HOLD_LAST);
    assign owner_drop  = !req[gnt_idx];
    assign release_now = done || owner_drop || at_limit;

    // Walk from the farthest offset back to ptr so the nearest requester wins.
    always_comb begin
        sel_idx = ptr;
        sel_hit = 1'b0;
        for (int k = 3; k >= 0; k--) begin
            if (req[ptr + 2'(k)]) begin
                sel_idx = ptr + 2'(k);
                sel_hit = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        idx_nxt     = gnt_idx;
        hold_nxt    = hold_cnt;
        valid_nxt   = gnt_valid;
        timeout_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (en && sel_hit) begin
                    state_nxt = GRANT;
                    idx_nxt   = sel_idx;
                    valid_nxt = 1'b1;
                    hold_nxt  = '0;
                end
            end
            GRANT: begin
                if (release_now) begin
                    state_nxt   = IDLE;
                    valid_nxt   = 1'b0;
                    ptr_nxt     = gnt_idx + 2'd1;
                    // A forced release only counts when nothing else ended the grant.
                    timeout_nxt = at_limit && !done && !owner_drop;
                end else begin
                    hold_nxt = hold_cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        gnt_nxt = valid_nxt ? (4'b0001 << idx_nxt) : 4'b0000;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= 2'd0;
            gnt_idx   <= 2'd0;
            hold_cnt  <= '0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
            gnt       <= 4'b0000;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            gnt_idx   <= idx_nxt;
            hold_cnt  <= hold_nxt;
            gnt_valid <= valid_nxt;
            timeout   <= timeout_nxt;
            gnt       <= gnt_nxt;
        end
    end

endmodule

// File: tb/tb_day6_rr_arbiter_4req.sv
// Directed bench for the four-requester round-robin arbiter.
module tb_day6_rr_arbiter_4req;

    logic       clk = 1'b0;
    logic       rst, en, done;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid, timeout;

    int errors = 0;
    int checks = 0;

    day6_rr_arbiter_4req #(.MAX_HOLD(8)) dut (
        .clk(clk), .rst(rst), .en(en), .req(req), .done(done),
        .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1; en = 1'b1; req = 4'b0000; done = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; en = 1'b1; req = 4'b1111; done = 1'b1;
        tick(); tick();
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
        checks++; if (gnt_idx !== 2'b00) begin errors++; $display("FAIL reset_idx got=%b exp=00", gnt_idx); end
        checks++; if (gnt_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", gnt_valid); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got=%b exp=0", timeout); end
        rst = 1'b0; done = 1'b0;
        tick();
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL reset_first_gnt got=%b exp=0001", gnt); end
        checks++; if (gnt_valid !== 1'b1) begin errors++; $display("FAIL reset_first_valid got=%b exp=1", gnt_valid); end
    endtask

    task automatic test_single;
        do_reset();
        req = 4'b0100;
        tick();
        checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL single_gnt got=%b exp=0100", gnt); end
        checks++; if (gnt_idx !== 2'd2) begin errors++; $display("FAIL single_idx got=%0d exp=2", gnt_idx); end
        tick(); tick();
        checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL single_hold got=%b exp=0100", gnt); end
        done = 1'b1;
        tick();
        done = 1'b0;
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL single_release got=%b exp=0000", gnt); end
        checks++; if (gnt_valid !== 1'b0) begin errors++; $display("FAIL single_rel_valid got=%b exp=0", gnt_valid); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL single_rel_timeout got=%b exp=0", timeout); end
        checks++; if (gnt_idx !== 2'd2) begin errors++; $display("FAIL single_idx_hold got=%0d exp=2", gnt_idx); end
        tick();
        checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL single_regrant got=%b exp=0100", gnt); end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_fairness;
        logic [3:0] exp_seq [5];
        exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        do_reset();
        req = 4'b1111; done = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (gnt !== exp_seq[i]) begin errors++; $display("FAIL fair_gnt[%0d] got=%b exp=%b", i, gnt, exp_seq[i]); end
            tick();
            checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL fair_gap[%0d] got=%b exp=0000", i, gnt); end
            checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL fair_timeout[%0d] got=%b exp=0", i, timeout); end
        end
        done = 1'b0; req = 4'b0000;
        tick();
    endtask

    task automatic test_timeout;
        do_reset();
        req = 4'b0010;
        tick();
        for (int i = 0; i < 8; i++) begin
            checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL to_hold[%0d] got=%b exp=0010", i, gnt); end
            checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL to_early[%0d] got=%b exp=0", i, timeout); end
            tick();
        end
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL to_release got=%b exp=0000", gnt); end
        checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL to_pulse got=%b exp=1", timeout); end
        tick();
        checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL to_regrant got=%b exp=0010", gnt); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL to_pulse_end got=%b exp=0", timeout); end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_coincident;
        do_reset();
        req = 4'b0010;
        tick();
        for (int i = 0; i < 7; i++) tick();
        checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL co_8th got=%b exp=0010", gnt); end
        done = 1'b1;
        tick();
        done = 1'b0;
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL co_release got=%b exp=0000", gnt); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL co_timeout got=%b exp=0", timeout); end
        tick();
        checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL co_regrant got=%b exp=0010", gnt); end
        tick();
        req = 4'b0000;
        tick();
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL drop_release got=%b exp=0000", gnt); end
        checks++; if (gnt_valid !== 1'b0) begin errors++; $display("FAIL drop_valid got=%b exp=0", gnt_valid); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL drop_timeout got=%b exp=0", timeout); end
    endtask

    task automatic test_enable_reset;
        do_reset();
        en = 1'b0; req = 4'b1000;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL en_block[%0d] got=%b exp=0000", i, gnt); end
        end
        en = 1'b1;
        tick();
        checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL en_grant got=%b exp=1000", gnt); end
        checks++; if (gnt_idx !== 2'd3) begin errors++; $display("FAIL en_idx got=%0d exp=3", gnt_idx); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL mid_rst_gnt got=%b exp=0000", gnt); end
        checks++; if (gnt_idx !== 2'd0) begin errors++; $display("FAIL mid_rst_idx got=%0d exp=0", gnt_idx); end
        req = 4'b1001;
        tick();
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL mid_rst_next got=%b exp=0001", gnt); end
        // Reset during owner 1's grant must not advance ptr to 2.
        req = 4'b0000;
        tick(); tick();
        req = 4'b0010;
        tick();
        checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL rst_ptr_setup got=%b exp=0010", gnt); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 4'b0110;
        tick();
        checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL rst_ptr_keep got=%b exp=0010", gnt); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_timeout();
        test_coincident();
        test_enable_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
